// File: rtl/snail_stream_sequencer.sv
// snail_stream_sequencer
// Shares one serial 1-0-1-1-0 pattern detector among N_REQ requesters. A job
// is one WORD_W-bit word. The selected word is latched, the detector is
// cleared, and the word is then fed to it MSB-first. One bit is stepped every
// TICK_DIV cycles. Detector hits are counted and reported with the owner ID.
//
// Handshake: a requester raises req_valid_i[i] and holds it, with its word
// stable, until req_ready_o[i] pulses for one cycle (the accept). Requests are
// sampled only while idle. The result is a one-cycle res_valid_o strobe with
// res_id_o/res_count_o and has no backpressure.
//
// Build option: define SNAIL_SEQ_FIXED_PRIO_EN for fixed priority (lowest
// index wins). Leave it undefined for round-robin starting at a rotating
// pointer.
module snail_stream_sequencer #(
   parameter int N_REQ    = 4,
   parameter int WORD_W   = 8,
   parameter int TICK_DIV = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req_valid_i,
   input  logic [N_REQ*WORD_W-1:0]      req_data_i,
   output logic [N_REQ-1:0]             req_ready_o,
   output logic                         det_rst_o,
   output logic                         det_en_o,
   output logic                         det_a_o,
   input  logic                         det_y_i,
   output logic                         res_valid_o,
   output logic [$clog2(N_REQ)-1:0]     res_id_o,
   output logic [$clog2(WORD_W+1)-1:0]  res_count_o,
   output logic                         busy_o,
   output logic [1:0]                   dbg_state_o
);

   localparam int ID_W   = $clog2(N_REQ);
   localparam int CNT_W  = $clog2(WORD_W + 1);
   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CLEAR  = 2'd1,
      ST_SHIFT  = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                det_rst_q, det_rst_d;

   logic                grant_found;
   logic [ID_W-1:0]     grant_idx;

`ifndef SNAIL_SEQ_FIXED_PRIO_EN
   logic [ID_W-1:0]     ptr_q, ptr_d;
`endif

   // Pick the requester to serve from the currently valid requests.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
`ifdef SNAIL_SEQ_FIXED_PRIO_EN
      // Scan from the top down so the lowest valid index is written last.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid_i[i]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'(i);
         end
      end
`else
      // Scan from the pointer and wrap around. The first valid index wins.
      for (int k = 0; k < N_REQ; k++) begin
         if (!grant_found && req_valid_i[(int'(ptr_q) + k) % N_REQ]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'((int'(ptr_q) + k) % N_REQ);
         end
      end
`endif
   end

   // Next-state and output decode for the IDLE/CLEAR/SHIFT/REPORT sequence.
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      id_d        = id_q;
      tick_d      = tick_q;
      bit_d       = bit_q;
      cnt_d       = cnt_q;
      det_rst_d   = 1'b0;
`ifndef SNAIL_SEQ_FIXED_PRIO_EN
      ptr_d       = ptr_q;
`endif
      req_ready_o = '0;
      det_en_o    = 1'b0;
      det_a_o     = 1'b0;
      res_valid_o = 1'b0;
      res_id_o    = '0;
      res_count_o = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (grant_found) begin
               req_ready_o[grant_idx] = 1'b1;
               for (int i = 0; i < N_REQ; i++) begin
                  if (grant_idx == ID_W'(i)) begin
                     word_d = req_data_i[i*WORD_W +: WORD_W];
                  end
               end
               id_d      = grant_idx;
               det_rst_d = 1'b1;
               state_d   = ST_CLEAR;
`ifndef SNAIL_SEQ_FIXED_PRIO_EN
               ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
`endif
            end
         end
         ST_CLEAR: begin
            cnt_d   = '0;
            tick_d  = '0;
            bit_d   = '0;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            // The word shifts left after each step, so its MSB is always the current bit.
            det_a_o = word_q[WORD_W-1];
            if (tick_q == TICK_LAST) begin
               det_en_o = 1'b1;
               tick_d   = '0;
               word_d   = word_q << 1;
               if (det_y_i) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (bit_q == BIT_LAST) begin
                  state_d = ST_REPORT;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         ST_REPORT: begin
            res_valid_o = 1'b1;
            res_id_o    = id_q;
            res_count_o = cnt_q;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and job registers. Reset aborts any job in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         word_q    <= '0;
         id_q      <= '0;
         tick_q    <= '0;
         bit_q     <= '0;
         cnt_q     <= '0;
         det_rst_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         id_q      <= id_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         cnt_q     <= cnt_d;
         det_rst_q <= det_rst_d;
      end
   end

`ifndef SNAIL_SEQ_FIXED_PRIO_EN
   // Round-robin pointer. It moves to the index after the last grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   assign det_rst_o   = det_rst_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_snail_stream_sequencer.sv
// Testbench for snail_stream_sequencer.
// The bench holds a behavioural model of the 1-0-1-1-0 detector that drives det_y.
// A per-requester job queue feeds the requests. The model predicts the job
// timeline from the accept cycle and finds each word's match count by a plain
// substring search. Literal checks pin the grant order, counts and latency.
module tb_snail_stream_sequencer;

   localparam int N       = 4;
   localparam int W       = 8;
   localparam int T       = 4;
   localparam int JOB_LAT = 2 + W*T;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [N*W-1:0]   req_data  = '0;
   logic [N-1:0]     req_ready_o;
   logic             det_rst_o, det_en_o, det_a_o, det_y;
   logic             res_valid_o, busy_o;
   logic [1:0]       res_id_o;
   logic [3:0]       res_count_o;
   logic [1:0]       dbg_state_o;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   snail_stream_sequencer #(.N_REQ(N), .WORD_W(W), .TICK_DIV(T)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_ready_o (req_ready_o),
      .det_rst_o   (det_rst_o),
      .det_en_o    (det_en_o),
      .det_a_o     (det_a_o),
      .det_y_i     (det_y),
      .res_valid_o (res_valid_o),
      .res_id_o    (res_id_o),
      .res_count_o (res_count_o),
      .busy_o      (busy_o),
      .dbg_state_o (dbg_state_o)
   );

   // ---------------- detector model ----------------
   // Remembers the last four stepped bits. y fires when those bits plus the
   // present input spell 10110. Matches may overlap.
   logic [3:0] d_hist;
   always @(posedge clk or posedge det_rst_o or posedge rst) begin
      if (rst || det_rst_o) d_hist <= 4'b0000;
      else if (det_en_o)    d_hist <= {d_hist[2:0], det_a_o};
   end
   assign det_y = ({d_hist, det_a_o} == 5'b10110);

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- driver ----------------
   logic [W-1:0] pend_word [N][16];
   int           pend_head [N];
   int           pend_tail [N];
   logic [N-1:0] drv_rdy;

   task automatic push(input int r, input logic [W-1:0] w);
      pend_word[r][pend_tail[r]] = w;
      pend_tail[r]++;
   endtask

   // Each requester presents its oldest pending word and drops it once accepted.
   initial begin
      forever begin
         @(negedge clk);
         drv_rdy = req_ready_o;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (drv_rdy[i]) pend_head[i]++;
            if (pend_head[i] < pend_tail[i]) begin
               req_valid[i]         = 1'b1;
               req_data[i*W +: W]   = pend_word[i][pend_head[i]];
            end else begin
               req_valid[i]         = 1'b0;
               req_data[i*W +: W]   = '0;
            end
         end
      end
   end

   // ---------------- model + scoreboard ----------------
   function automatic int count_matches(input logic [W-1:0] w);
      int c = 0;
      for (int j = 0; j <= W - 5; j++)
         if (w[W-1-j -: 5] == 5'b10110) c++;
      return c;
   endfunction

   function automatic int pick(input logic [N-1:0] v, input int ptr);
`ifdef SNAIL_SEQ_FIXED_PRIO_EN
      for (int i = 0; i < N; i++)
         if (v[i]) return i + 0*ptr;
`else
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
`endif
      return -1;
   endfunction

   logic [3:0]   exp_q[$];
   bit           m_active = 1'b0;
   int           m_t, m_id, m_ptr = 0;
   logic [W-1:0] m_word;

   int grant_log[$], grant_cyc[$];
   int res_id_log[$], res_cnt_log[$], res_cyc_log[$];

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clk) begin : compare
      logic [N-1:0] e_ready;
      logic         e_rst, e_en, e_a, e_valid, e_busy;
      int           e_id, e_cnt, phase, g, s;
      e_ready = '0; e_rst = 0; e_en = 0; e_a = 0; e_valid = 0; e_busy = 0;
      e_id = 0; e_cnt = 0;
      if (rst) begin
         m_active = 1'b0;
         m_ptr    = 0;
         exp_q.delete();
         chk("rst_busy", busy_o, 0);
         chk("rst_det_en", det_en_o, 0);
         chk("rst_res_valid", res_valid_o, 0);
         chk("rst_req_ready", req_ready_o, 0);
      end else begin
         if (!m_active) begin
            g = pick(req_valid, m_ptr);
            if (g >= 0) begin
               e_ready[g] = 1'b1;
               m_active   = 1'b1;
               m_t        = cyc;
               m_id       = g;
               m_word     = req_data[g*W +: W];
               exp_q.push_back(4'(count_matches(m_word)));
               m_ptr      = (g + 1) % N;
            end
         end else begin
            phase = cyc - m_t;
            e_busy = 1'b1;
            if (phase == 1) begin
               e_rst = 1'b1;
            end else if (phase >= 2 && phase < JOB_LAT) begin
               s    = phase - 2;
               e_a  = m_word[W-1 - s/T];
               e_en = ((s % T) == T - 1);
            end else begin
               e_valid  = 1'b1;
               e_id     = m_id;
               e_cnt    = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
               m_active = 1'b0;
            end
         end
         chk("req_ready", req_ready_o, e_ready);
         chk("det_rst", det_rst_o, e_rst);
         chk("det_en", det_en_o, e_en);
         chk("det_a", det_a_o, e_a);
         chk("res_valid", res_valid_o, e_valid);
         chk("busy", busy_o, e_busy);
         if (e_valid) begin
            chk("res_id", res_id_o, e_id);
            chk("res_count", res_count_o, e_cnt);
         end
         for (int i = 0; i < N; i++)
            if (req_ready_o[i]) begin grant_log.push_back(i); grant_cyc.push_back(cyc); end
         if (res_valid_o) begin
            res_id_log.push_back(int'(res_id_o));
            res_cnt_log.push_back(int'(res_count_o));
            res_cyc_log.push_back(cyc);
         end
      end
   end

   // ---------------- directed sequence ----------------
   task automatic wait_res(input int n);
      int k = 0;
      while (res_id_log.size() < n && k < 300) begin @(negedge clk); k++; end
      chk("result_timeout", res_id_log.size(), n);
   endtask

   task automatic wait_grant(input int n);
      int k = 0;
      while (grant_log.size() < n && k < 300) begin @(negedge clk); k++; end
      chk("grant_timeout", grant_log.size(), n);
   endtask

   task automatic do_reset();
      @(negedge clk); #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
   endtask

`ifdef SNAIL_SEQ_FIXED_PRIO_EN
   int rr_g[6] = '{1, 1, 3, 3, 0, 1};
   int rr_c[6] = '{2, 0, 1, 2, 1, 1};
`else
   int rr_g[6] = '{1, 3, 1, 3, 0, 1};
   int rr_c[6] = '{2, 1, 0, 2, 1, 1};
`endif

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("por_busy", busy_o, 0);
      chk("por_req_ready", req_ready_o, 0);
      chk("por_det_rst", det_rst_o, 0);
      chk("por_res_valid", res_valid_o, 0);
      chk("por_res_count", res_count_o, 0);
      #1 rst = 1'b0;

      // single job from requester 0
      push(0, 8'b1011_0000);
      wait_res(1);
      chk("t1_grant", grant_log[0], 0);
      chk("t1_id", res_id_log[0], 0);
      chk("t1_count", res_cnt_log[0], 1);
      chk("t1_latency", res_cyc_log[0] - grant_cyc[0], 34);

      // words without a complete pattern
      push(2, 8'b1011_1011); wait_res(2);
      push(1, 8'h00);        wait_res(3);
      chk("t2_id_req2", res_id_log[1], 2);
      chk("t2_cnt_req2", res_cnt_log[1], 0);
      chk("t2_id_req1", res_id_log[2], 1);
      chk("t2_cnt_req1", res_cnt_log[2], 0);

      // the detector must be cleared between words
      push(0, 8'b0000_1011); wait_res(4);
      push(0, 8'b0110_0000); wait_res(5);
      chk("clr_cnt_a", res_cnt_log[3], 0);
      chk("clr_cnt_b", res_cnt_log[4], 0);

      // arbitration with competing requesters
      do_reset();
      push(1, 8'hB6); push(3, 8'h5A); push(1, 8'hFF); push(3, 8'hB6);
      wait_res(9);
      push(0, 8'hD8); push(1, 8'h16);
      wait_res(11);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("arb_grant%0d", i), grant_log[5+i], rr_g[i]);
         chk($sformatf("arb_count%0d", i), res_cnt_log[5+i], rr_c[i]);
      end

      // reset in the middle of a shift aborts the job
      push(2, 8'b1011_0000);
      wait_grant(12);
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", busy_o, 0);
      chk("abort_det_en", det_en_o, 0);
      chk("abort_res_valid", res_valid_o, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("abort_no_result", res_id_log.size(), 11);

      // the pointer restarts at 0 after reset
      push(0, 8'b1011_0000); push(3, 8'h00);
      wait_res(13);
      chk("post_rst_grant0", grant_log[12], 0);
      chk("post_rst_grant1", grant_log[13], 3);
      chk("post_rst_cnt0", res_cnt_log[11], 1);

      push(2, 8'b1011_0000);
      wait_res(14);
      chk("recover_id", res_id_log[13], 2);
      chk("recover_count", res_cnt_log[13], 1);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/snail_stream_sequencer.md
# snail_stream_sequencer

Controller that shares a single serial pattern detector (ports `en`, `a`, `y`, async `rst`; asserts Mealy output `y` on the bit sequence 1-0-1-1-0) among `N_REQ` requesters. It arbitrates word-sized jobs, clears the detector, and serializes each word into it MSB-first at a paced bit rate. It counts detector hits per word and reports the count with the requester ID. It sits between requester logic and the detector instance in the lab top level.

## Interface
- `N_REQ`, 4: number of requesters (≥2).
- `WORD_W`, 8: bits per job word.
- `TICK_DIV`, 4: clock cycles per serialized bit (≥1).
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in N_REQ: job request per requester.
- `req_data` in N_REQ*WORD_W: job words; requester i occupies bits [i*WORD_W +: WORD_W].
- `req_ready` out N_REQ: one-hot, one-cycle accept pulse.
- `det_rst` out 1: detector clear, registered.
- `det_en` out 1: detector step strobe.
- `det_a` out 1: detector serial input bit.
- `det_y` in 1: detector match output, combinational in `det_a`.
- `res_valid` out 1: one-cycle result strobe.
- `res_id` out $clog2(N_REQ): requester that owned the result.
- `res_count` out $clog2(WORD_W+1): number of matches in the word.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- Reset: all outputs are 0, state is IDLE, round-robin pointer is 0, bit/tick counters are 0, match count is 0.
- FSM states are IDLE → CLEAR → SHIFT → REPORT → IDLE.
- IDLE:
  - If any `req_valid` is high, grant index g, pulse `req_ready[g]`, latch `req_data[g]` and g, and go to CLEAR. Otherwise stay.
  - Round-robin: search starts at the pointer and wraps modulo N_REQ. After a grant, pointer = (g+1) mod N_REQ.
- CLEAR: `det_rst`=1 for exactly this cycle. Zero the match count. Go to SHIFT.
- SHIFT:
  - `det_a` = latched word bit [WORD_W-1-b], where b is the bit index 0..WORD_W-1.
  - The tick counter counts 0..TICK_DIV-1. `det_en`=1 only when the tick counter equals TICK_DIV-1.
  - In a cycle where `det_en`=1 and `det_y`=1, increment `res_count` (saturation is not needed; width covers WORD_W).
  - After the `det_en` of bit WORD_W-1, go to REPORT.
- REPORT: `res_valid`=1 for one cycle, with `res_id` and `res_count` valid in that cycle. Return to IDLE. No backpressure.
- Requesters must hold `req_valid` and `req_data` stable until `req_ready`. A request that drops before its grant is ignored. New requests are only sampled in IDLE.
- `det_a` and `det_en` are 0 outside SHIFT.
- Reset mid-operation aborts the current job. No `res_valid` is issued for it, and the pointer returns to 0.

## Timing
- With the accept (`req_ready`) in cycle t:
  - `det_rst` is high in t+1.
  - SHIFT spans t+2 … t+1+WORD_W*TICK_DIV.
  - `res_valid` is high in t+2+WORD_W*TICK_DIV.
- With defaults, `res_valid` arrives 34 cycles after accept.
- Back-to-back jobs: the next accept can occur in the cycle after REPORT, so the minimum job period is WORD_W*TICK_DIV+3 cycles.
- `det_y` is sampled in the same cycle as `det_en`.

## Configuration
- `SNAIL_SEQ_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins, pointer unused.
  - Undefined (default): round-robin as described above.

## Test plan
- Single job, req 0, 8'b1011_0000 (defaults) → `req_ready[0]` pulses, `res_valid` arrives 34 cycles later with `res_id`=0 and `res_count`=1.
- Req 2 sends 8'b1011_1011 → `res_count`=0 (1 after S4 gives no match); req 1 sends 8'h00 → `res_count`=0.
- Clear check: 8'b0000_1011 then 8'b0110_0000 → both report `res_count`=0. This proves `det_rst` prevents state leaking across words.
- Round-robin: reqs 1 and 3 held valid from reset → grants 1, 3, 1, 3. Then reqs 0 and 1 valid after a grant to 3 → grant 0 then 1.
- Assert `rst` midway through SHIFT → `busy`, `det_en`, and `res_valid` go to 0 immediately, and no result is issued. A req 2 job afterwards completes normally with `res_id`=2.
- With `SNAIL_SEQ_FIXED_PRIO_EN`: reqs 1 and 3 held valid → req 1 is granted every job and req 3 never.
